// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: load-use stall, branch flush and memory-freeze sequencer driving the pipeline register enables.
module idex_hazard_ctrl #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IFID_rs1,
   input  logic [4:0]       IFID_rs2,
   input  logic             IFID_use_rs1,
   input  logic             IFID_use_rs2,
   input  logic [4:0]       IDEX_rd,
   input  logic             IDEX_MemoryRead,
   input  logic             EX_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_write,
   output logic             IDEX_bubble,
   output logic             EXMEM_write,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] LU_STALL = 2'd1;
   localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             lu_hit, frz, brk, stl;

   assign lu_hit = IDEX_MemoryRead & (IDEX_rd != 5'd0) &
                   ((IFID_use_rs1 & (IFID_rs1 == IDEX_rd)) | (IFID_use_rs2 & (IFID_rs2 == IDEX_rd)));
   // one-hot priority: freeze > flush > stall; reset forces all three low
   assign frz = ~reset & mem_busy;
   assign brk = ~reset & ~mem_busy & EX_branch_taken;
   assign stl = ~reset & ~mem_busy & ~EX_branch_taken & (lu_hit | (state_q == LU_STALL));

   assign pc_write     = ~frz & ~stl;
   assign IFID_write   = ~frz & ~stl;
   assign IFID_flush   = brk;
   assign IDEX_write   = ~frz;
   assign IDEX_bubble  = brk | stl;
   assign EXMEM_write  = ~frz;
   assign hz_state     = state_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (brk) begin
         state_d = RUN;
         cnt_d   = 3'd0;
      end else if (stl && state_q == RUN) begin
         state_d = (LOAD_LAT == 1) ? RUN : LU_STALL;
         cnt_d   = LAT_M1;
      end else if (stl) begin
         state_d = (cnt_q == 3'd1) ? RUN : LU_STALL;
         cnt_d   = cnt_q - 3'd1;
      end
   end

   assign stall_d = (~pc_write & ~&stall_q) ? stall_q + 1'b1 : stall_q;
   assign flush_d = (IFID_flush & ~&flush_q) ? flush_q + 1'b1 : flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end
endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb_idex_hazard_ctrl: scoreboard bench driving LOAD_LAT=1, LOAD_LAT=3 and CNT_W=4 instances from shared stimulus.
module tb_idex_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] rs1, rs2, rd;
   logic use1, use2, mr, br, busy;
   logic [2:0][5:0]  ctl;
   logic [2:0][1:0]  hs;
   logic [1:0][15:0] sc, fc;
   logic [3:0] sc4, fc4;
   int total = 0;
   int bad = 0;

   typedef struct {
      int ctl;
      int st;
      int sc;
      int fc;
   } exp_t;
   exp_t q[$];

   int lat[3] = '{1, 3, 1};
   int mx[3]  = '{65535, 65535, 15};
   int m_st[3], m_cnt[3], m_sc[3], m_fc[3];

   always #5 clk = ~clk;

   idex_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
      .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_use_rs1(use1), .IFID_use_rs2(use2),
      .IDEX_rd(rd), .IDEX_MemoryRead(mr), .EX_branch_taken(br), .mem_busy(busy),
      .pc_write(ctl[0][5]), .IFID_write(ctl[0][4]), .IFID_flush(ctl[0][3]), .IDEX_write(ctl[0][2]),
      .IDEX_bubble(ctl[0][1]), .EXMEM_write(ctl[0][0]), .hz_state(hs[0]), .stall_cycles(sc[0]), .flush_count(fc[0]));
   idex_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
      .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_use_rs1(use1), .IFID_use_rs2(use2),
      .IDEX_rd(rd), .IDEX_MemoryRead(mr), .EX_branch_taken(br), .mem_busy(busy),
      .pc_write(ctl[1][5]), .IFID_write(ctl[1][4]), .IFID_flush(ctl[1][3]), .IDEX_write(ctl[1][2]),
      .IDEX_bubble(ctl[1][1]), .EXMEM_write(ctl[1][0]), .hz_state(hs[1]), .stall_cycles(sc[1]), .flush_count(fc[1]));
   idex_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_c4 (
      .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_use_rs1(use1), .IFID_use_rs2(use2),
      .IDEX_rd(rd), .IDEX_MemoryRead(mr), .EX_branch_taken(br), .mem_busy(busy),
      .pc_write(ctl[2][5]), .IFID_write(ctl[2][4]), .IFID_flush(ctl[2][3]), .IDEX_write(ctl[2][2]),
      .IDEX_bubble(ctl[2][1]), .EXMEM_write(ctl[2][0]), .hz_state(hs[2]), .stall_cycles(sc4), .flush_count(fc4));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit hit();
      return mr && rd != 0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
   endfunction

   // 0 normal, 1 frozen, 2 flush, 3 stall
   function automatic int mode(int i);
      if (reset) return 0;
      if (busy) return 1;
      if (br) return 2;
      if (m_st[i] == 1 || hit()) return 3;
      return 0;
   endfunction

   function automatic int ctl_of(int m);
      // bit order {pc, IFID_w, flush, IDEX_w, bubble, EXMEM_w}
      case (m)
         1: return 6'b000000;
         2: return 6'b111111;
         3: return 6'b000111;
         default: return 6'b110101;
      endcase
   endfunction

   task automatic model_step(int i);
      int m;
      m = mode(i);
      if (reset) begin
         m_st[i] = 0; m_cnt[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
         return;
      end
      if ((m == 1 || m == 3) && m_sc[i] < mx[i]) m_sc[i]++;
      if (m == 2 && m_fc[i] < mx[i]) m_fc[i]++;
      if (m == 2) begin
         m_st[i] = 0; m_cnt[i] = 0;
      end else if (m == 3) begin
         if (m_st[i] == 0) begin
            if (lat[i] > 1) begin m_st[i] = 1; m_cnt[i] = lat[i] - 1; end
         end else begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) m_st[i] = 0;
         end
      end
   endtask

   function automatic int got_sc(int i);
      return i == 2 ? int'(sc4) : int'(sc[i]);
   endfunction

   function automatic int got_fc(int i);
      return i == 2 ? int'(fc4) : int'(fc[i]);
   endfunction

   task automatic cyc();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.ctl = ctl_of(mode(i));
         e.st = m_st[i];
         e.sc = m_sc[i];
         e.fc = m_fc[i];
         q.push_back(e);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         e = q.pop_front();
         chk($sformatf("ctl%0d", i), int'(ctl[i]), e.ctl);
         chk($sformatf("state%0d", i), int'(hs[i]), e.st);
         chk($sformatf("stall_cycles%0d", i), got_sc(i), e.sc);
         chk($sformatf("flush_count%0d", i), got_fc(i), e.fc);
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
   endtask

   task automatic idle();
      mr = 0; br = 0; busy = 0; use1 = 0; use2 = 0; rs1 = 0; rs2 = 0; rd = 0;
   endtask

   task automatic rst_pulse();
      idle();
      reset = 1;
      cyc();
      reset = 0;
   endtask

   task automatic hazard();
      mr = 1; rd = 5; rs1 = 5; use1 = 1;
   endtask

   initial begin
      reset = 1;
      idle();
      for (int i = 0; i < 3; i++) begin m_st[i] = 0; m_cnt[i] = 0; m_sc[i] = 0; m_fc[i] = 0; end
      @(posedge clk);
      #1;
      cyc();
      reset = 0;
      // load-use, single-cycle latency
      hazard(); cyc();
      idle(); cyc();
      chk("t1_l1_stalls", got_sc(0), 1);
      // x0 and unused operand never hazard
      rst_pulse();
      mr = 1; rd = 0; rs1 = 0; use1 = 1; cyc();
      rd = 7; rs1 = 0; use1 = 0; rs2 = 7; use2 = 0; cyc();
      chk("t2_no_stall", got_sc(0), 0);
      // three-cycle load latency
      rst_pulse();
      hazard(); cyc();
      idle(); cyc(); cyc(); cyc();
      chk("t3_l3_stalls", got_sc(1), 3);
      chk("t3_l3_run", int'(hs[1]), 0);
      // freeze in the middle of a stall
      rst_pulse();
      hazard(); cyc();
      idle(); busy = 1; cyc(); cyc();
      busy = 0; cyc(); cyc(); cyc();
      chk("t4_l3_stalls", got_sc(1), 5);
      // branch aborts a stall
      rst_pulse();
      hazard(); cyc();
      idle(); br = 1; cyc();
      br = 0; cyc();
      chk("t5_flushes", got_fc(1), 1);
      chk("t5_run", int'(hs[1]), 0);
      // saturation of narrow counters, then reset
      rst_pulse();
      busy = 1;
      repeat (20) cyc();
      chk("t6_sat", got_sc(2), 15);
      rst_pulse();
      chk("t6_clr", got_sc(2), 0);
      // random traffic
      repeat (300) begin
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
         use1 = 1'($urandom); use2 = 1'($urandom); mr = 1'($urandom);
         br = ($urandom_range(0, 7) == 0); busy = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 40) == 0);
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
